// File: rtl/tv80_alu_pkg.sv
// Shared definitions for the TV80-style add/logic/multiply/divide unit:
// opcode constants, FSM state encoding, default flag bit positions and a
// small parity helper.
package tv80_alu_pkg;

  // Opcodes presented on req_op. Values 10..15 are illegal.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_CP  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  // Control FSM: IDLE accepts, CALC iterates MUL/DIV, DONE presents a result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default positions of each flag inside the 8-bit flag byte.
  localparam int FLAG_C_POS = 0;
  localparam int FLAG_N_POS = 1;
  localparam int FLAG_P_POS = 2;
  localparam int FLAG_X_POS = 3;
  localparam int FLAG_H_POS = 4;
  localparam int FLAG_Y_POS = 5;
  localparam int FLAG_Z_POS = 6;
  localparam int FLAG_S_POS = 7;

  // 1 when the byte holds an even number of ones.
  function automatic logic even_parity8(input logic [7:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/tv80_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One bit per clock, DW steps per operation. Operands are captured on
// start; done is high during the final step and q/r then carry the
// finished result (low product / quotient on q, high product / remainder
// on r). Only instantiated when TV80_MULDIV_EN is defined.
module tv80_muldiv_iter
  import tv80_alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    op,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [DW-1:0] r
);

  localparam int CW = $clog2(DW);

  // hi/lo form one 2*DW working register:
  //   MUL: hi = partial product, lo = multiplier shifting out / product low
  //   DIV: hi = partial remainder, lo = dividend shifting out / quotient
  logic          active_q, active_d;
  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] m_q, m_d;

  logic [DW:0]   mul_sum;
  logic [DW:0]   div_sh;
  logic          div_ge;
  logic [DW-1:0] div_diff;
  logic [DW-1:0] step_hi;
  logic [DW-1:0] step_lo;

  // One multiply or divide step computed from the current working register.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(DW+1){1'b0}});
    div_sh   = {hi_q, lo_q[DW-1]};
    div_ge   = (div_sh >= {1'b0, m_q});
    // The true difference is below m_q, so DW bits are enough.
    div_diff = div_sh[DW-1:0] - m_q;
    if (div_q) begin
      step_hi = div_ge ? div_diff : div_sh[DW-1:0];
      step_lo = {lo_q[DW-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DW:1];
      step_lo = {mul_sum[0], lo_q[DW-1:1]};
    end
    done = active_q && (cnt_q == CW'(DW - 1));
    q    = step_lo;
    r    = step_hi;
  end

  // Next-state: load on start, otherwise step while active.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    if (start) begin
      active_d = 1'b1;
      div_d    = (op == OP_DIV);
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = (op == OP_DIV) ? a : b;
      m_d      = (op == OP_DIV) ? b : a;
    end else if (active_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + CW'(1);
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  // Iteration registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
    end
  end

endmodule

// File: rtl/tv80_muldiv_alu.sv
// TV80-style ALU with optional iterative unsigned multiply/divide.
// Add/logic ops and illegal opcodes answer one cycle after accept; MUL and
// DIV (non-zero divisor) spend DW cycles in CALC. Build macro
// TV80_MULDIV_EN enables MUL/DIV; without it opcodes 8/9 are illegal and
// no iteration datapath exists.
//
// Handshake: a request is taken on a clock edge where req_valid && req_ready;
// a result is released on a clock edge where rsp_valid && rsp_ready, and
// rsp_q/rsp_r/rsp_f hold steady until then. req_ready is high only in IDLE.
module tv80_muldiv_alu
  import tv80_alu_pkg::*;
#(
  parameter int DW     = 8,
  parameter int Flag_C = FLAG_C_POS,
  parameter int Flag_N = FLAG_N_POS,
  parameter int Flag_P = FLAG_P_POS,
  parameter int Flag_X = FLAG_X_POS,
  parameter int Flag_H = FLAG_H_POS,
  parameter int Flag_Y = FLAG_Y_POS,
  parameter int Flag_Z = FLAG_Z_POS,
  parameter int Flag_S = FLAG_S_POS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [7:0]    req_f,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_q,
  output logic [DW-1:0] rsp_r,
  output logic [7:0]    rsp_f,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  state_e        state_q, state_d;
  logic [DW-1:0] qval_q, qval_d;
  logic [DW-1:0] rval_q, rval_d;
  logic [7:0]    fval_q, fval_d;

  logic          accept;
  logic          is_sub;
  logic          cin;
  logic          cin_eff;
  logic [DW-1:0] b_eff;
  logic [DW:0]   add_sum;
  logic          ovf;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] alu_r;
  logic [7:0]    alu_f;
  logic          alu_iter;

  function automatic logic [7:0] pack_flags(input logic s, input logic z,
                                            input logic y, input logic h,
                                            input logic x, input logic p,
                                            input logic n, input logic c);
    logic [7:0] f;
    f         = 8'h00;
    f[Flag_S] = s;
    f[Flag_Z] = z;
    f[Flag_Y] = y;
    f[Flag_H] = h;
    f[Flag_X] = x;
    f[Flag_P] = p;
    f[Flag_N] = n;
    f[Flag_C] = c;
    return f;
  endfunction

  assign accept    = req_valid && req_ready;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign rsp_q     = qval_q;
  assign rsp_r     = rval_q;
  assign rsp_f     = fval_q;

  // Single-cycle result for add/logic/illegal ops; flags MUL/DIV for CALC.
  always_comb begin
    is_sub  = (req_op == OP_SUB) || (req_op == OP_SBC) || (req_op == OP_CP);
    cin     = ((req_op == OP_ADC) || (req_op == OP_SBC)) ? req_f[Flag_C] : 1'b0;
    // Subtraction as a + ~b + ~borrow_in; carries are inverted to borrows.
    b_eff   = is_sub ? ~req_b : req_b;
    cin_eff = is_sub ? ~cin : cin;
    add_sum = {1'b0, req_a} + {1'b0, b_eff} + {{DW{1'b0}}, cin_eff};
    ovf     = (req_a[DW-1] == b_eff[DW-1]) && (add_sum[DW-1] != req_a[DW-1]);
    // Illegal opcodes fall through with operands/flags passed back.
    alu_q    = req_a;
    alu_r    = '0;
    alu_f    = req_f;
    alu_iter = 1'b0;
    case (req_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
        // CP keeps A; S/Z follow rsp_q while X/Y come from the operand.
        alu_q = (req_op == OP_CP) ? req_a : add_sum[DW-1:0];
        alu_f = pack_flags(alu_q[DW-1], alu_q == '0,
                           (req_op == OP_CP) ? req_b[5] : add_sum[5],
                           req_a[4] ^ b_eff[4] ^ add_sum[4] ^ is_sub,
                           (req_op == OP_CP) ? req_b[3] : add_sum[3],
                           ovf, is_sub, add_sum[DW] ^ is_sub);
      end
      OP_AND, OP_XOR, OP_OR: begin
        if (req_op == OP_AND) begin
          alu_q = req_a & req_b;
        end else if (req_op == OP_XOR) begin
          alu_q = req_a ^ req_b;
        end else begin
          alu_q = req_a | req_b;
        end
        alu_f = pack_flags(alu_q[DW-1], alu_q == '0, alu_q[5],
                           req_op == OP_AND, alu_q[3],
                           even_parity8(alu_q[7:0]), 1'b0, 1'b0);
      end
`ifdef TV80_MULDIV_EN
      OP_MUL: begin
        alu_iter = 1'b1;
      end
      OP_DIV: begin
        if (req_b == '0) begin
          alu_q = '1;
          alu_r = req_a;
          alu_f = pack_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end else begin
          alu_iter = 1'b1;
        end
      end
`endif
      default: begin
        alu_q = req_a;
      end
    endcase
  end

`ifdef TV80_MULDIV_EN
  logic          op_div_q, op_div_d;
  logic          iter_start;
  logic          iter_done;
  logic [DW-1:0] iter_q;
  logic [DW-1:0] iter_r;
  logic [7:0]    iter_f;

  assign iter_start = accept && alu_iter;

  tv80_muldiv_iter #(
    .DW(DW)
  ) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (iter_start),
    .a       (req_a),
    .b       (req_b),
    .op      (req_op),
    .done    (iter_done),
    .q       (iter_q),
    .r       (iter_r)
  );

  // Flags for a finished MUL (Z over the full product) or DIV.
  always_comb begin
    if (op_div_q) begin
      iter_f = pack_flags(iter_q[DW-1], iter_q == '0, iter_q[5], 1'b0,
                          iter_q[3], 1'b0, 1'b0, 1'b0);
    end else begin
      iter_f = pack_flags(iter_q[DW-1], (iter_q == '0) && (iter_r == '0),
                          iter_q[5], 1'b0, iter_q[3], iter_r != '0, 1'b0,
                          iter_r != '0);
    end
  end
`endif

  // Control FSM and result registers.
  always_comb begin
    state_d = state_q;
    qval_d  = qval_q;
    rval_d  = rval_q;
    fval_d  = fval_q;
`ifdef TV80_MULDIV_EN
    op_div_d = op_div_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (alu_iter) begin
            state_d = ST_CALC;
`ifdef TV80_MULDIV_EN
            op_div_d = (req_op == OP_DIV);
`endif
          end else begin
            state_d = ST_DONE;
            qval_d  = alu_q;
            rval_d  = alu_r;
            fval_d  = alu_f;
          end
        end
      end
      ST_CALC: begin
`ifdef TV80_MULDIV_EN
        if (iter_done) begin
          state_d = ST_DONE;
          qval_d  = iter_q;
          rval_d  = iter_r;
          fval_d  = iter_f;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result flops; reset drops any pending or in-flight result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      qval_q   <= '0;
      rval_q   <= '0;
      fval_q   <= '0;
`ifdef TV80_MULDIV_EN
      op_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      qval_q   <= qval_d;
      rval_q   <= rval_d;
      fval_q   <= fval_d;
`ifdef TV80_MULDIV_EN
      op_div_q <= op_div_d;
`endif
    end
  end

endmodule

// File: doc/tv80_muldiv_alu.md
TV80_MULDIV_ALU -- requirements
Module: tv80_muldiv_alu

Interface
REQ-001 Parameter DW, default 8: operand and result width, legal range 8..32.
REQ-002 Parameter Flag_C/N/P/X/H/Y/Z/S, defaults 0/1/2/3/4/5/6/7: bit positions of each flag in the 8-bit flag byte.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  request present; req_ready  out  1  block can accept.
REQ-006 req_op  in  4  opcode: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 MUL, 9 DIV, 10-15 illegal.
REQ-007 req_a, req_b  in  DW  operands; req_f  in  8  incoming flag byte.
REQ-008 rsp_valid  out  1  result present; rsp_ready  in  1  consumer accepts the result.
REQ-009 rsp_q  out  DW  primary result (sum, logic result, product low half, quotient).
REQ-010 rsp_r  out  DW  secondary result (product high half, remainder); 0 for all other ops.
REQ-011 rsp_f  out  8  outgoing flag byte; busy  out  1  high while state is not IDLE.

Function
REQ-012 The block SHALL implement three states. IDLE: req_ready=1. CALC: iterating MUL/DIV. DONE: rsp_valid=1.
REQ-013 Accept SHALL occur only on req_valid&&req_ready; operands and op SHALL be registered at accept, and input changes afterwards SHALL have no effect.
REQ-014 Ops 0-7, illegal ops, and DIV with req_b==0 SHALL go IDLE->DONE with rsp_valid asserted on the cycle after accept (latency 1).
REQ-015 MUL (unsigned shift-add) and DIV (unsigned restoring) SHALL take exactly DW cycles in CALC; rsp_valid SHALL rise DW+1 cycles after accept.
REQ-016 In DONE, rsp_q/rsp_r/rsp_f SHALL hold stable until rsp_valid&&rsp_ready; then the block SHALL return to IDLE, and the next accept is possible no earlier than the following cycle.
REQ-017 ADD/ADC/SUB/SBC/CP: carry-in = ADC/SBC ? req_f[Flag_C] : 0. C = carry out of bit DW-1 (borrow for subtraction). H = carry/borrow out of bit 3. P = signed overflow. N = 1 for SUB/SBC/CP, else 0. CP SHALL not change rsp_q, which returns req_a.
REQ-018 AND/XOR/OR: C=0, N=0, H=1 for AND else 0, P = even parity of rsp_q[7:0].
REQ-019 For all ops 0-9: S = rsp_q[DW-1]; Z = (rsp_q==0), except MUL, where Z = (full product==0). X/Y = result bits 3/5; for CP they SHALL be req_b bits 3/5.
REQ-020 MUL flags: C = P = (rsp_r!=0), N = H = 0.
REQ-021 DIV flags: C = N = H = 0, P = 0.
REQ-022 DIV by zero SHALL give rsp_q = all ones, rsp_r = req_a, P = 1.
REQ-023 An illegal op SHALL give rsp_q = req_a, rsp_r = 0, rsp_f = req_f.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE with rsp_valid=0, busy=0, and rsp_q, rsp_r, rsp_f and all iteration registers = 0; req_ready SHALL be 1 after reset. Reset asserted mid-CALC SHALL abandon the operation, and no response SHALL be produced for it.

Configuration
REQ-025 Macro TV80_MULDIV_EN defined: MUL/DIV SHALL behave as specified above. Undefined: ops 8 and 9 SHALL be treated as illegal (REQ-023, latency 1), no CALC state or iteration datapath SHALL be synthesised, and the busy output SHALL still exist.

Structure
REQ-026 Package tv80_alu_pkg SHALL hold the opcode constants, the state enum, and the default flag bit positions.
REQ-027 The iterative datapath SHALL be a sub-module tv80_muldiv_iter (start, done, a, b, op, q, r), instantiated only under TV80_MULDIV_EN; the add/logic datapath stays in the top.

Verification (DW=8)
REQ-028 ADD 0x7F+0x01, req_f=0x00 -> rsp_q=0x80, S=1 Z=0 H=1 P=1 N=0 C=0, rsp_valid one cycle after accept.
REQ-029 SBC 0x00-0x00 with req_f C=1 -> rsp_q=0xFF, C=1 H=1 N=1 S=1 P=0.
REQ-030 MUL 0xFF*0xFF -> rsp_q=0x01, rsp_r=0xFE, C=P=1, rsp_valid exactly 9 cycles after accept, req_ready=0 throughout.
REQ-031 DIV 100/7 -> rsp_q=0x0E, rsp_r=0x02, P=0; DIV 100/0 -> rsp_q=0xFF, rsp_r=0x64, P=1, latency 1.
REQ-032 Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_valid ignored; then pulse rsp_ready -> IDLE on the next cycle.
REQ-033 Assert reset_n=0 in cycle 4 of a MUL -> rsp_valid=0 and busy=0 immediately; after release, ADD 1+1 -> rsp_q=0x02 with correct flags.
